// File: rtl/instr_mem_loader.sv
// RV32I instruction encoder and byte-serial instruction memory loader.
// Assembles a machine word from decoded fields, then writes it LE, 1 byte/cycle.
module instr_mem_loader #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [31:0]       imm,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;

  state_t            state;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       word;
  logic [31:0]       enc;
  logic              legal;

  // upper immediate bits never reach any instruction format
  logic unused_imm;
  assign unused_imm = ^imm[31:13];

  assign next_addr = word_addr + 1'b1;
  assign in_ready  = (state == IDLE) && !clear;

  // combinational encoder: field bundle -> machine word
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (in_type)
      3'd0: enc = {(funct7b5 ? 7'b0100000 : 7'b0), rs2, rs1,
                   funct3, rd, OP_R};
      3'd1: enc = {imm[11:0], rs1, funct3, rd, OP_L};
      3'd2: begin
        if (funct3 == 3'b101)
          enc = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, OP_I};
        else if (funct3 == 3'b001)
          enc = {7'b0, imm[4:0], rs1, funct3, rd, OP_I};
        else
          enc = {imm[11:0], rs1, funct3, rd, OP_I};
      end
      3'd3: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      3'd4: enc = {imm[12], imm[10:5], rs2, rs1, funct3,
                   imm[4:1], imm[11], OP_B};
      default: legal = 1'b0;
    endcase
  end

  // sequencer: outputs are registered one step ahead, so state WRk shows byte k
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      word_addr <= BASE;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= {BASE, 2'b00};
      mem_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            word_addr <= BASE;
            mem_addr  <= {BASE, 2'b00};
          end else if (in_valid) begin
            if (legal) begin
              word      <= enc;
              state     <= WR0;
              mem_we    <= 1'b1;
              busy      <= 1'b1;
              mem_addr  <= {word_addr, 2'b00};
              mem_wdata <= enc[7:0];
            end else begin
              err <= 1'b1;
            end
          end
        end
        WR0: begin
          state     <= WR1;
          mem_addr  <= {word_addr, 2'b01};
          mem_wdata <= word[15:8];
        end
        WR1: begin
          state     <= WR2;
          mem_addr  <= {word_addr, 2'b10};
          mem_wdata <= word[23:16];
        end
        WR2: begin
          state     <= WR3;
          mem_addr  <= {word_addr, 2'b11};
          mem_wdata <= word[31:24];
        end
        WR3: begin
          state     <= IDLE;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          mem_wdata <= '0;
          word_addr <= next_addr;
          mem_addr  <= {next_addr, 2'b00};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// Reference encoder built from field bit positions; address model mod 2^AW.
module tb_instr_mem_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_type = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]    funct3 = '0;
  logic          funct7b5 = 1'b0;
  logic [31:0]   imm = '0;
  logic          clear = 1'b0;
  logic          mem_we;
  logic [AW+1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          err;

  int total = 0;
  int bad = 0;
  int model_addr = 0;

  logic          obs_we[4];
  logic [AW+1:0] obs_addr[4];
  logic [7:0]    obs_data[4];
  logic          obs_busy[4];
  logic          obs_ready5;
  logic          obs_we5;

  instr_mem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7b5(funct7b5), .imm(imm), .clear(clear), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(
    input logic [2:0] t, input logic [4:0] d, s1, s2,
    input logic [2:0] f3, input logic f7, input logic [31:0] im);
    logic [31:0] w;
    logic [31:0] base;
    base = (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15);
    w = 0;
    case (t)
      3'd0: w = 32'h33 | base | (32'(s2) << 20) | (f7 ? 32'h4000_0000 : 0);
      3'd1: w = 32'h03 | base | ((im & 32'hFFF) << 20);
      3'd2: begin
        if (f3 == 3'd5)
          w = 32'h13 | base | ((im & 32'h1F) << 20) | (32'(f7) << 30);
        else if (f3 == 3'd1)
          w = 32'h13 | base | ((im & 32'h1F) << 20);
        else
          w = 32'h13 | base | ((im & 32'hFFF) << 20);
      end
      3'd3: w = 32'h23 | (32'(f3) << 12) | (32'(s1) << 15)
              | (32'(s2) << 20) | ((im & 32'h1F) << 7)
              | (((im >> 5) & 32'h7F) << 25);
      3'd4: w = 32'h63 | (32'(f3) << 12) | (32'(s1) << 15)
              | (32'(s2) << 20) | (((im >> 11) & 1) << 7)
              | (((im >> 1) & 32'hF) << 8) | (((im >> 5) & 32'h3F) << 25)
              | (((im >> 12) & 1) << 31);
      default: w = 0;
    endcase
    return w;
  endfunction

  // waits for in_ready (bounded) then presents one bundle for one edge
  task automatic send(input logic [2:0] t, input logic [4:0] d, s1, s2,
                      input logic [2:0] f3, input logic f7,
                      input logic [31:0] im, input bit hold);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
    end
    in_type = t; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7b5 = f7; imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // records cycles N+1..N+5 after an accept; optional clear pulse in WR1
  task automatic capture(input int clr_k);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == clr_k) clear = 1'b1;
      else clear = 1'b0;
      obs_we[k] = mem_we; obs_addr[k] = mem_addr;
      obs_data[k] = mem_wdata; obs_busy[k] = busy;
    end
    @(negedge clk);
    clear = 1'b0;
    obs_ready5 = in_ready;
    obs_we5 = mem_we;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0 ||
        mem_wdata !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset: got rdy=%b we=%b addr=%h d=%h busy=%b err=%b want 1 0 0 00 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, err);
    end
    reset = 1'b0;
    model_addr = 0;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [31:0] exp;
    exp = 32'h002081B3;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
    capture(-1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_we[k] !== 1'b1 || obs_busy[k] !== 1'b1 ||
          obs_addr[k] !== (AW+2)'(model_addr * 4 + k) ||
          obs_data[k] !== exp[8*k +: 8]) begin
        bad++;
        $display("FAIL add byte%0d: got we=%b busy=%b addr=%0d d=%h want 1 1 %0d %h",
                 k, obs_we[k], obs_busy[k], obs_addr[k], obs_data[k],
                 model_addr * 4 + k, exp[8*k +: 8]);
      end
    end
    total++;
    if (obs_ready5 !== 1'b1 || obs_we5 !== 1'b0) begin
      bad++;
      $display("FAIL add_ready5: got rdy=%b we=%b want 1 0", obs_ready5, obs_we5);
    end
    model_addr = (model_addr + 1) % (1 << AW);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ty[3] = '{3'd0, 3'd1, 3'd3};
    logic [4:0]  dd[3] = '{5'd5, 5'd4, 5'd0};
    logic [4:0]  a1[3] = '{5'd6, 5'd2, 5'd2};
    logic [4:0]  a2[3] = '{5'd7, 5'd0, 5'd5};
    logic [2:0]  f3[3] = '{3'd0, 3'd2, 3'd2};
    logic        f7[3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] im[3] = '{32'd0, 32'd8, 32'd12};
    logic [31:0] ex[3] = '{32'h407302B3, 32'h00812203, 32'h00512623};
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      send(ty[i], dd[i], a1[i], a2[i], f3[i], f7[i], im[i], i < 2);
      capture(-1);
      exp = ex[i];
      for (int k = 0; k < 4; k++) begin
        total++;
        if (obs_we[k] !== 1'b1 ||
            obs_addr[k] !== (AW+2)'(model_addr * 4 + k) ||
            obs_data[k] !== exp[8*k +: 8]) begin
          bad++;
          $display("FAIL b2b%0d byte%0d: got we=%b addr=%0d d=%h want 1 %0d %h",
                   i, k, obs_we[k], obs_addr[k], obs_data[k],
                   model_addr * 4 + k, exp[8*k +: 8]);
        end
      end
      total++;
      if (obs_ready5 !== 1'b1) begin
        bad++;
        $display("FAIL b2b%0d_ready5: got %b want 1", i, obs_ready5);
      end
      model_addr = (model_addr + 1) % (1 << AW);
    end
  endtask

  task automatic test_imm_forms();
    logic [2:0]  ty[2] = '{3'd2, 3'd4};
    logic [4:0]  dd[2] = '{5'd1, 5'd0};
    logic [4:0]  a1[2] = '{5'd1, 5'd1};
    logic [4:0]  a2[2] = '{5'd0, 5'd2};
    logic [2:0]  f3[2] = '{3'd5, 3'd0};
    logic        f7[2] = '{1'b1, 1'b0};
    logic [31:0] im[2] = '{32'd3, 32'hFFFF_FFFC};
    logic [31:0] ex[2] = '{32'h4030D093, 32'hFE208EE3};
    logic [31:0] exp;
    for (int i = 0; i < 2; i++) begin
      send(ty[i], dd[i], a1[i], a2[i], f3[i], f7[i], im[i], 1'b0);
      capture(-1);
      exp = ex[i];
      for (int k = 0; k < 4; k++) begin
        total++;
        if (obs_we[k] !== 1'b1 ||
            obs_addr[k] !== (AW+2)'(model_addr * 4 + k) ||
            obs_data[k] !== exp[8*k +: 8]) begin
          bad++;
          $display("FAIL imm%0d byte%0d: got we=%b addr=%0d d=%h want 1 %0d %h",
                   i, k, obs_we[k], obs_addr[k], obs_data[k],
                   model_addr * 4 + k, exp[8*k +: 8]);
        end
      end
      model_addr = (model_addr + 1) % (1 << AW);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] exp;
    in_type = 3'd6; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL illegal_err: got err=%b we=%b busy=%b want 1 0 0", err, mem_we, busy);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse: got err=%b we=%b want 0 0", err, mem_we);
    end
    exp = ref_word(3'd2, 5'd9, 5'd4, 5'd0, 3'd0, 1'b0, 32'h7FF);
    send(3'd2, 5'd9, 5'd4, 5'd0, 3'd0, 1'b0, 32'h7FF, 1'b0);
    capture(-1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_we[k] !== 1'b1 ||
          obs_addr[k] !== (AW+2)'(model_addr * 4 + k) ||
          obs_data[k] !== exp[8*k +: 8]) begin
        bad++;
        $display("FAIL after_illegal byte%0d: got we=%b addr=%0d d=%h want 1 %0d %h",
                 k, obs_we[k], obs_addr[k], obs_data[k],
                 model_addr * 4 + k, exp[8*k +: 8]);
      end
    end
    model_addr = (model_addr + 1) % (1 << AW);
  endtask

  task automatic test_wrap_clear();
    logic [31:0] exp;
    logic [2:0]  t;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] im;
    in_type = 3'd0; in_valid = 1'b1; clear = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL clear_noaccept: got we=%b busy=%b addr=%0d want 0 0 0",
               mem_we, busy, mem_addr);
    end
    model_addr = 0;
    for (int i = 0; i < 5; i++) begin
      t = 3'($urandom_range(0, 4));
      d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 1'($urandom); im = $urandom;
      exp = ref_word(t, d, s1, s2, f3, f7, im);
      send(t, d, s1, s2, f3, f7, im, 1'b0);
      capture(i == 1 ? 1 : -1);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (obs_we[k] !== 1'b1 ||
            obs_addr[k] !== (AW+2)'(model_addr * 4 + k) ||
            obs_data[k] !== exp[8*k +: 8]) begin
          bad++;
          $display("FAIL wrap%0d byte%0d: got we=%b addr=%0d d=%h want 1 %0d %h",
                   i, k, obs_we[k], obs_addr[k], obs_data[k],
                   model_addr * 4 + k, exp[8*k +: 8]);
        end
      end
      model_addr = (model_addr + 1) % (1 << AW);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== (AW+2)'(model_addr * 4 + 2)) begin
      bad++;
      $display("FAIL mid_wr2: got we=%b addr=%0d want 1 %0d",
               mem_we, mem_addr, model_addr * 4 + 2);
    end
    reset = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL mid_reset: got we=%b busy=%b addr=%0d want 0 0 0",
               mem_we, busy, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || mem_addr !== '0) begin
      bad++;
      $display("FAIL post_reset: got rdy=%b addr=%0d want 1 0", in_ready, mem_addr);
    end
    model_addr = 0;
    @(negedge clk);
    exp = ref_word(3'd3, 5'd0, 5'd8, 5'd9, 3'd2, 1'b0, 32'hFFFF_FFF0);
    send(3'd3, 5'd0, 5'd8, 5'd9, 3'd2, 1'b0, 32'hFFFF_FFF0, 1'b0);
    capture(-1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_we[k] !== 1'b1 || obs_addr[k] !== (AW+2)'(k) ||
          obs_data[k] !== exp[8*k +: 8]) begin
        bad++;
        $display("FAIL after_reset byte%0d: got we=%b addr=%0d d=%h want 1 %0d %h",
                 k, obs_we[k], obs_addr[k], obs_data[k], k, exp[8*k +: 8]);
      end
    end
    model_addr = 1;
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [2:0]  t;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] im;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_addr = 0;
      end
      t = 3'($urandom_range(0, 5));
      if (t == 3'd5) t = 3'($urandom_range(5, 7));
      d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 1'($urandom); im = $urandom;
      if (t > 3'd4) begin
        in_type = t; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (err !== 1'b1 || mem_we !== 1'b0 ||
            mem_addr !== (AW+2)'(model_addr * 4)) begin
          bad++;
          $display("FAIL rnd%0d illegal: got err=%b we=%b addr=%0d want 1 0 %0d",
                   i, err, mem_we, mem_addr, model_addr * 4);
        end
      end else begin
        exp = ref_word(t, d, s1, s2, f3, f7, im);
        send(t, d, s1, s2, f3, f7, im, 1'b0);
        capture(-1);
        for (int k = 0; k < 4; k++) begin
          total++;
          if (obs_we[k] !== 1'b1 ||
              obs_addr[k] !== (AW+2)'(model_addr * 4 + k) ||
              obs_data[k] !== exp[8*k +: 8]) begin
            bad++;
            $display("FAIL rnd%0d byte%0d: got we=%b addr=%0d d=%h want 1 %0d %h",
                     i, k, obs_we[k], obs_addr[k], obs_data[k],
                     model_addr * 4 + k, exp[8*k +: 8]);
          end
        end
        total++;
        if (obs_ready5 !== 1'b1 || obs_we5 !== 1'b0) begin
          bad++;
          $display("FAIL rnd%0d ready5: got rdy=%b we=%b want 1 0", i, obs_ready5, obs_we5);
        end
        model_addr = (model_addr + 1) % (1 << AW);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_imm_forms();
    test_illegal();
    test_wrap_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
